serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller. It sequences a single 1-bit full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock, with the carry held in a flip-flop between bits. It sits in the arithmetic datapath as a low-area alternative to a ripple adder. The upstream requester uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
cin  input  1  carry-in for add; ignored when sub=1.
op_a  input  WIDTH  operand A; sampled with start.
op_b  input  WIDTH  operand B; sampled with start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when result is valid.
result  output  WIDTH  sum/difference; held until the next accepted start.
cout  output  1  final carry-out; for subtract, 1 = no borrow.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: all outputs 0; internal shift registers, carry FF and counter 0; state = IDLE. Assertion is asynchronous; deassertion is used synchronously by the surrounding design.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE: when start=1 at a clock edge:
  - a_sh <= op_a.
  - b_sh <= sub ? ~op_b : op_b.
  - carry <= sub ? 1 : cin.
  - cnt <= 0.
  - result, cout, ovf are cleared to 0.
  - Go to RUN.
  - When start=0, stay in IDLE with outputs held.
- RUN, each cycle:
  - Full-adder inputs are a_sh[0], b_sh[0], carry.
  - The sum bit shifts into result at the MSB end (result <= {s, result[WIDTH-1:1]}).
  - a_sh and b_sh shift right by one; carry <= full-adder carry-out; cnt++.
  - When cnt == WIDTH-1, the pre-update carry is captured as c_msb_in, and the state moves to DONE.
- RUN occupies exactly WIDTH cycles.
- DONE, for one cycle:
  - done=1.
  - cout = carry.
  - ovf = c_msb_in ^ carry.
  - Next state is IDLE.
- Latency: start is accepted at edge 0; done is high during the cycle after edge WIDTH. The result is therefore visible WIDTH+1 cycles after acceptance.
- busy goes high the cycle after start is accepted and drops the cycle after done.
- start while busy is ignored: no queueing and no effect on the operation in progress.
- start asserted in the DONE cycle is also ignored. It is accepted on the following IDLE edge, so back-to-back throughput is WIDTH+2 cycles per operation.
- op_a, op_b, sub and cin may change freely after acceptance without affecting the operation in progress.
- Reset mid-operation aborts immediately: no done pulse, all outputs 0, state IDLE.
- Arithmetic is modulo 2**WIDTH.
- Subtract is implemented as a + ~b + 1.
- result, cout and ovf are registered outputs. They are stable from the done cycle until the next accepted start.

Decomposition:
- A shared include file `arith_defs.vh` holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the op codes OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: the team's structural full adder `fad_str`, built from two half adders and an OR. It is instanced once as the per-bit arithmetic cell.
- The controller itself contains the FSM, shift registers, carry FF and counter, with no further hierarchy.

Test Plan (WIDTH=8):
1. Add: start with a=8'h5A, b=8'h3C, sub=0, cin=0 → done exactly 9 cycles after acceptance; result=8'h96, cout=0, ovf=1.
2. Add with wrap: a=8'hFF, b=8'h01, cin=0 → result=8'h00, cout=1, ovf=0. Repeat with cin=1 → result=8'h01, cout=1.
3. Subtract, borrow: a=8'h10, b=8'h20, sub=1, cin=1 (ignored) → result=8'hF0, cout=0, ovf=0.
4. Subtract, overflow: a=8'h80, b=8'h01, sub=1 → result=8'h7F, cout=1, ovf=1.
5. Protocol:
   - Hold start high continuously, changing op_a/op_b every cycle. Only the operands at each IDLE acceptance are used.
   - done pulses are exactly 1 cycle wide and spaced 10 cycles apart.
   - busy is low only on acceptance edges.
6. Reset abort: drop rst_n during the 4th RUN cycle → busy, done, result, cout, ovf are 0 immediately, with no done pulse. Then release reset and start a=8'h01, b=8'h02 → result=8'h03 after 9 cycles.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and operation codes.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between an upstream requester (master) and the
// serial add/subtract controller (slave).
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_fad_str.sv
// Structural 1-bit full adder: two half adders whose carries are ORed.
module fad_str (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g;
    logic g2;

    // first half adder on a/b, second on the partial sum and carry-in
    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign g2 = p & ci;
    assign co = g | g2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first
// over WIDTH bits, carry held in a flip-flop between bits.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               fa_s;
    logic               fa_co;
    logic               last_bit;

    fad_str u_fa (
        .a  (a_sh_reg[0]),
        .b  (b_sh_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_bit)  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Flags are captured on the final RUN edge so they are already valid in
    // the done cycle; the carry entering the MSB is carry_reg at that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_reg   <= bus.op_a;
                        b_sh_reg   <= (bus.sub == OP_SUB) ? ~bus.op_b : bus.op_b;
                        carry_reg  <= (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        cout_reg   <= 1'b0;
                        ovf_reg    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_reg <= {fa_s, result_reg[WIDTH-1:1]};
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    carry_reg  <= fa_co;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        cout_reg <= fa_co;
                        ovf_reg  <= carry_reg ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_reg != ST_IDLE);
    assign bus.done   = (state_reg == ST_DONE);
    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;
endmodule
